// File: rtl/pixel_frame_writer_pkg.sv
// Shared definitions for the pixel frame writer: frame FSM states,
// pixel channel sizing, default frame geometry and a width helper.
package pixel_frame_writer_pkg;

  localparam int CHANNEL_W          = 8;
  localparam int NUM_CHANNELS       = 3;
  localparam int PIXEL_W            = CHANNEL_W * NUM_CHANNELS;

  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_HEIGHT     = 32;
  localparam int DEFAULT_ADDR_BITS  = 10;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } frameState_e;

  // Number of bits needed to index n items; never less than one bit.
  function automatic int bitsFor(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO between the shader and the framebuffer port.
// The owner gates push_i with "not full" and pop_i with "not empty", so
// this block does not re-check occupancy. DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module pixel_fifo
  import pixel_frame_writer_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int DATA_W = PIXEL_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DATA_W-1:0]      wdata_i,
  output logic [DATA_W-1:0]      rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = bitsFor(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Storage array: only written on push; contents are meaningless until counted in.
  always_ff @(posedge clock) begin
    if (push_i) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy update; push+pop together leaves the count unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push_i) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (pop_i) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared by reset so stale entries are discarded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/pixel_frame_writer.sv
// Pixel frame writer: buffers shader pixels in a small FIFO and streams
// them to the framebuffer in raster order (address y*WIDTH+x) while a
// frame is running. Frame FSM, raster counters and the registered
// framebuffer port live here; buffering lives in pixel_fifo.
module pixel_frame_writer
  import pixel_frame_writer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int HEIGHT     = DEFAULT_HEIGHT,
  parameter int ADDR_BITS  = DEFAULT_ADDR_BITS,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_wr_en,
  input  logic [CHANNEL_W-1:0] pixel [NUM_CHANNELS-1:0],
  output logic                 in_full,
  input  logic                 start,
  input  logic                 fb_ready,
  output logic                 fb_we,
  output logic [ADDR_BITS-1:0] fb_addr,
  output logic [PIXEL_W-1:0]   fb_data,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int XW    = bitsFor(WIDTH);
  localparam int YW    = bitsFor(HEIGHT);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  frameState_e          state_q, state_d;
  logic [XW-1:0]        pixX_q, pixX_d;
  logic [YW-1:0]        pixY_q, pixY_d;
  logic                 fbWe_q, fbWe_d;
  logic [ADDR_BITS-1:0] fbAddr_q, fbAddr_d;
  logic [PIXEL_W-1:0]   fbData_q, fbData_d;
  logic                 frameDone_q, frameDone_d;
  logic                 overflow_q, overflow_d;

  logic [CNT_W-1:0]     fifoCount;
  logic [PIXEL_W-1:0]   fifoRdata;
  logic [PIXEL_W-1:0]   packedPixel;
  logic                 fifoFull;
  logic                 pushEn;
  logic                 popEn;
  logic                 lastPixel;
  int                   linearAddr;

  assign packedPixel = {pixel[2], pixel[1], pixel[0]};

  // Full is decoded from the registered count, so a pop in the same cycle
  // cannot make room for a push that arrives while full.
  assign fifoFull  = (fifoCount == CNT_W'(FIFO_DEPTH));
  assign pushEn    = in_wr_en && !fifoFull;
  assign popEn     = (state_q == RUN) && (fifoCount != '0) && fb_ready;
  assign lastPixel = (pixX_q == XW'(WIDTH - 1)) && (pixY_q == YW'(HEIGHT - 1));

  pixel_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (PIXEL_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (pushEn),
    .pop_i   (popEn),
    .wdata_i (packedPixel),
    .rdata_o (fifoRdata),
    .count_o (fifoCount)
  );

  // Frame FSM next state: start is only honoured outside RUN; RUN ends on the last pixel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (popEn && lastPixel) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Frame FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Raster counters, framebuffer port and sticky overflow next-state logic.
  always_comb begin
    pixX_d      = pixX_q;
    pixY_d      = pixY_q;
    fbWe_d      = popEn;
    fbAddr_d    = fbAddr_q;
    fbData_d    = fbData_q;
    frameDone_d = popEn && lastPixel;
    overflow_d  = overflow_q || (in_wr_en && fifoFull);
    // Full-width product first, then narrow to the framebuffer address width.
    linearAddr  = int'(pixY_q) * WIDTH + int'(pixX_q);
    if (popEn) begin
      fbAddr_d = ADDR_BITS'(linearAddr);
      fbData_d = fifoRdata;
      if (pixX_q == XW'(WIDTH - 1)) begin
        pixX_d = '0;
        if (pixY_q == YW'(HEIGHT - 1)) begin
          pixY_d = '0;
        end else begin
          pixY_d = pixY_q + YW'(1);
        end
      end else begin
        pixX_d = pixX_q + XW'(1);
      end
    end
  end

  // Registered framebuffer outputs and raster position; reset drops any partial frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixX_q      <= '0;
      pixY_q      <= '0;
      fbWe_q      <= 1'b0;
      fbAddr_q    <= '0;
      fbData_q    <= '0;
      frameDone_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      pixX_q      <= pixX_d;
      pixY_q      <= pixY_d;
      fbWe_q      <= fbWe_d;
      fbAddr_q    <= fbAddr_d;
      fbData_q    <= fbData_d;
      frameDone_q <= frameDone_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_full    = fifoFull;
  assign fb_we      = fbWe_q;
  assign fb_addr    = fbAddr_q;
  assign fb_data    = fbData_q;
  assign frame_done = frameDone_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Bench for pixel_frame_writer: a default-size instance checked every cycle
// against a queue-based frame model, plus a 4x2 instance for raster wrap.
module tb_pixel_frame_writer;

   localparam int DEPTH = 4;
   localparam int FRAME = 1024;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        wrEn = 1'b0;
   logic [23:0] pixWord = '0;
   logic [7:0]  pix [2:0];
   logic        inFull;
   logic        start = 1'b0;
   logic        fbReady = 1'b0;
   logic        fbWe;
   logic [9:0]  fbAddr;
   logic [23:0] fbData;
   logic        frameDone;
   logic        overflow;

   logic        sReset = 1'b0;
   logic        sWr = 1'b0;
   logic [23:0] sPixWord = '0;
   logic [7:0]  sPix [2:0];
   logic        sInFull;
   logic        sStart = 1'b0;
   logic        sReady = 1'b0;
   logic        sWe;
   logic [2:0]  sAddr;
   logic [23:0] sData;
   logic        sDone;
   logic        sOvf;

   int          checks = 0;
   int          fails = 0;
   int          weCount = 0;
   int          doneCount = 0;
   logic [31:0] doneAddr = '0;

   logic [23:0] mQ [$];
   bit          mRun = 1'b0;
   int          mIdx = 0;
   bit          mOvf = 1'b0;
   bit          mWe = 1'b0;
   bit          mDone = 1'b0;
   logic [31:0] mAddr = '0;
   logic [23:0] mData = '0;

   // Free-running clock for both instances.
   always #5 clock = ~clock;

   // Split the packed stimulus words into channel arrays (R, G, B).
   always_comb begin
      pix[2]  = pixWord[23:16];
      pix[1]  = pixWord[15:8];
      pix[0]  = pixWord[7:0];
      sPix[2] = sPixWord[23:16];
      sPix[1] = sPixWord[15:8];
      sPix[0] = sPixWord[7:0];
   end

   pixel_frame_writer dut (
      .clock      (clock),
      .reset      (reset),
      .in_wr_en   (wrEn),
      .pixel      (pix),
      .in_full    (inFull),
      .start      (start),
      .fb_ready   (fbReady),
      .fb_we      (fbWe),
      .fb_addr    (fbAddr),
      .fb_data    (fbData),
      .frame_done (frameDone),
      .overflow   (overflow)
   );

   pixel_frame_writer #(
      .WIDTH      (4),
      .HEIGHT     (2),
      .ADDR_BITS  (3),
      .FIFO_DEPTH (4)
   ) dutSmall (
      .clock      (clock),
      .reset      (sReset),
      .in_wr_en   (sWr),
      .pixel      (sPix),
      .in_full    (sInFull),
      .start      (sStart),
      .fb_ready   (sReady),
      .fb_we      (sWe),
      .fb_addr    (sAddr),
      .fb_data    (sData),
      .frame_done (sDone),
      .overflow   (sOvf)
   );

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of main-instance inputs at the falling edge.
   task automatic applyStimulus(input logic wr, input logic [23:0] p, input logic st, input logic rdy);
      @(negedge clock);
      wrEn    = wr;
      pixWord = p;
      start   = st;
      fbReady = rdy;
   endtask

   // Pulse reset on the main instance and pin every output to zero.
   task automatic doReset();
      @(negedge clock);
      reset   = 1'b1;
      wrEn    = 1'b0;
      start   = 1'b0;
      fbReady = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("rst_fb_we", 32'(fbWe), 32'd0);
      checkOutput("rst_fb_addr", 32'(fbAddr), 32'd0);
      checkOutput("rst_fb_data", 32'(fbData), 32'd0);
      checkOutput("rst_frame_done", 32'(frameDone), 32'd0);
      checkOutput("rst_overflow", 32'(overflow), 32'd0);
      checkOutput("rst_in_full", 32'(inFull), 32'd0);
      reset = 1'b0;
   endtask

   function automatic logic [23:0] pixOf(input int i);
      logic [31:0] v;
      v = i;
      if (i == 0) return 24'h112233;
      return {v[7:0], v[15:8] ^ 8'h5A, ~v[7:0]};
   endfunction

   // Frame model: a pixel queue, a running flag and a raster index, advanced
   // at each rising edge; the DUT outputs are then compared 1 time unit later.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mQ.delete();
         mRun  = 1'b0;
         mIdx  = 0;
         mOvf  = 1'b0;
         mWe   = 1'b0;
         mDone = 1'b0;
         mAddr = '0;
         mData = '0;
      end else begin
         bit fullNow, doPush, doPop, wasRun;
         fullNow = (mQ.size() == DEPTH);
         doPush  = wrEn && !fullNow;
         doPop   = mRun && (mQ.size() > 0) && fbReady;
         wasRun  = mRun;
         if (wrEn && fullNow) mOvf = 1'b1;
         mWe   = doPop;
         mDone = 1'b0;
         if (doPop) begin
            mData = mQ.pop_front();
            mAddr = mIdx;
            if (mIdx == FRAME - 1) begin
               mDone = 1'b1;
               mRun  = 1'b0;
            end
            mIdx = (mIdx + 1) % FRAME;
         end
         if (!wasRun && start) mRun = 1'b1;
         if (doPush) mQ.push_back(pixWord);
      end
      #1;
      checkOutput("fb_we", 32'(fbWe), 32'(mWe));
      checkOutput("frame_done", 32'(frameDone), 32'(mDone));
      checkOutput("in_full", 32'(inFull), 32'(mQ.size() == DEPTH));
      checkOutput("overflow", 32'(overflow), 32'(mOvf));
      if (mWe) begin
         checkOutput("fb_addr", 32'(fbAddr), mAddr);
         checkOutput("fb_data", 32'(fbData), 32'(mData));
      end
      if (fbWe) weCount++;
      if (frameDone) begin
         doneCount++;
         doneAddr = 32'(fbAddr);
      end
   end

   // Watchdog so a stuck run still terminates.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int weBase;
      int sCnt;
      logic [31:0] sAddrLog [16];
      logic [31:0] sDataLog [16];
      logic        sDoneLog [16];

      #2 reset = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("init_fb_we", 32'(fbWe), 32'd0);
      checkOutput("init_in_full", 32'(inFull), 32'd0);
      reset = 1'b0;

      // Full frame at one pixel per cycle; first pixel pins two-edge latency.
      applyStimulus(1'b0, 24'h0, 1'b1, 1'b1);
      for (int i = 0; i < FRAME; i++) begin
         applyStimulus(1'b1, pixOf(i), 1'b0, 1'b1);
         if (i == 2) begin
            checkOutput("lat_fb_we", 32'(fbWe), 32'd1);
            checkOutput("lat_fb_data", 32'(fbData), 32'h112233);
            checkOutput("lat_fb_addr", 32'(fbAddr), 32'd0);
         end
      end
      repeat (4) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
      checkOutput("frame_we_count", 32'(weCount), 32'd1024);
      checkOutput("frame_done_count", 32'(doneCount), 32'd1);
      checkOutput("frame_done_addr", doneAddr, 32'd1023);

      // Finished frame: a pushed pixel must wait for the next start.
      applyStimulus(1'b1, 24'hABCDEF, 1'b0, 1'b1);
      repeat (5) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
      checkOutput("done_no_write", 32'(weCount), 32'd1024);

      // Backpressure: four pushes fill the FIFO, the fifth is dropped.
      doReset();
      applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 24'hA00001, 1'b0, 1'b0);
      applyStimulus(1'b1, 24'hA00002, 1'b0, 1'b0);
      applyStimulus(1'b1, 24'hA00003, 1'b0, 1'b0);
      applyStimulus(1'b1, 24'hA00004, 1'b0, 1'b0);
      checkOutput("bp_full_before4", 32'(inFull), 32'd0);
      applyStimulus(1'b1, 24'hA00005, 1'b0, 1'b0);
      checkOutput("bp_full_after4", 32'(inFull), 32'd1);
      checkOutput("bp_ovf_before5", 32'(overflow), 32'd0);
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      checkOutput("bp_ovf_after5", 32'(overflow), 32'd1);
      weBase = weCount;
      repeat (8) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
      checkOutput("bp_drained", 32'(weCount - weBase), 32'd4);
      checkOutput("bp_ovf_sticky", 32'(overflow), 32'd1);

      // Full FIFO with push and pop together: push refused, count drops to 3.
      doReset();
      applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 24'hB00001, 1'b0, 1'b0);
      applyStimulus(1'b1, 24'hB00002, 1'b0, 1'b0);
      applyStimulus(1'b1, 24'hB00003, 1'b0, 1'b0);
      applyStimulus(1'b1, 24'hB00004, 1'b0, 1'b0);
      applyStimulus(1'b1, 24'hB0DEAD, 1'b0, 1'b1);
      applyStimulus(1'b1, 24'hB00005, 1'b0, 1'b1);
      checkOutput("sim_full_cleared", 32'(inFull), 32'd0);
      checkOutput("sim_overflow", 32'(overflow), 32'd1);
      applyStimulus(1'b1, 24'hB00006, 1'b0, 1'b0);
      checkOutput("sim_count_held", 32'(inFull), 32'd0);
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      checkOutput("sim_count_was3", 32'(inFull), 32'd1);
      repeat (8) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);

      // Reset mid-frame with pixels still buffered.
      doReset();
      applyStimulus(1'b0, 24'h0, 1'b1, 1'b1);
      for (int i = 0; i < 100; i++) applyStimulus(1'b1, pixOf(i + 7), 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 24'hC00000 + 24'(i), 1'b0, 1'b0);
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      doReset();
      weBase = weCount;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 24'hD00000 + 24'(i), 1'b0, 1'b1);
      repeat (10) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
      checkOutput("rst_no_write_before_start", 32'(weCount - weBase), 32'd0);
      applyStimulus(1'b0, 24'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
      checkOutput("rst_restart_we", 32'(fbWe), 32'd1);
      checkOutput("rst_restart_addr", 32'(fbAddr), 32'd0);
      checkOutput("rst_restart_data", 32'(fbData), 32'hD00000);
      repeat (4) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);

      // 4x2 frame on the small instance: raster wrap and frame_done position.
      @(negedge clock);
      sReset = 1'b1;
      repeat (2) @(negedge clock);
      sReset = 1'b0;
      sStart = 1'b1;
      sReady = 1'b1;
      sCnt = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clock);
         if (sWe && sCnt < 16) begin
            sAddrLog[sCnt] = 32'(sAddr);
            sDataLog[sCnt] = 32'(sData);
            sDoneLog[sCnt] = sDone;
            sCnt++;
         end
         sStart   = 1'b0;
         sWr      = (c < 8);
         sPixWord = 24'h100000 + 24'(c);
      end
      sWr = 1'b0;
      checkOutput("small_we_count", 32'(sCnt), 32'd8);
      if (sCnt == 8) begin
         for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("small_addr%0d", k), sAddrLog[k], 32'(k));
            checkOutput($sformatf("small_data%0d", k), sDataLog[k], 32'h100000 + 32'(k));
            checkOutput($sformatf("small_done%0d", k), 32'(sDoneLog[k]), 32'(k == 7));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/pixel_frame_writer.md
PIXEL_FRAME_WRITER -- requirements
Module: pixel_frame_writer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning pixels per row.
REQ-002 The block SHALL have parameter HEIGHT, default 32, meaning rows per frame.
REQ-003 The block SHALL have parameter ADDR_BITS, default 10, meaning framebuffer address width (2^ADDR_BITS >= WIDTH*HEIGHT).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, meaning pixel FIFO entries (power of two).
REQ-005 The block SHALL have ports clock, input, 1, sole clock, all logic on posedge.
REQ-006 The block SHALL have ports reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have ports in_wr_en, input, 1, pixel write strobe from the shader.
REQ-008 The block SHALL have ports pixel, input, 3x8 unpacked [2:0], channel 2 = R, 1 = G, 0 = B.
REQ-009 The block SHALL have ports in_full, output, 1, FIFO full (backpressure to shader).
REQ-010 The block SHALL have ports start, input, 1, one-cycle frame start request.
REQ-011 The block SHALL have ports fb_ready, input, 1, framebuffer accepts a write this cycle.
REQ-012 The block SHALL have ports fb_we, output, 1, framebuffer write enable.
REQ-013 The block SHALL have ports fb_addr, output, ADDR_BITS, linear address y*WIDTH+x.
REQ-014 The block SHALL have ports fb_data, output, 24, {pixel[2],pixel[1],pixel[0]}.
REQ-015 The block SHALL have ports frame_done, output, 1, one-cycle pulse after last pixel write.
REQ-016 The block SHALL have ports overflow, output, 1, sticky flag for a write attempted while full.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE on last-pixel write; DONE->RUN on start; start SHALL be ignored in RUN.
REQ-018 A push SHALL occur when in_wr_en=1 and in_full=0, in any state.
REQ-019 in_full SHALL equal (count == FIFO_DEPTH), decoded from registered count.
REQ-020 in_wr_en while in_full=1 SHALL drop the pixel and set overflow, even if a pop occurs that cycle.
REQ-021 A pop SHALL occur when state=RUN, count>0 and fb_ready=1.
REQ-022 fb_we, fb_addr and fb_data SHALL be registered: the pop at edge N drives fb_we=1 for the cycle after edge N; fb_we=0 otherwise.
REQ-023 Minimum latency SHALL be 2 edges: push at edge N, earliest pop at edge N+1.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-025 Counters x, y SHALL advance on each pop: x wraps WIDTH-1->0 with y+1; at x=WIDTH-1, y=HEIGHT-1 both wrap to 0.
REQ-026 frame_done SHALL pulse one cycle coincident with fb_we of pixel (WIDTH-1, HEIGHT-1).
REQ-027 The FIFO SHALL keep accepting pushes in IDLE/DONE until full and SHALL drain only in RUN.
REQ-028 fb_addr SHALL be computed without truncation before narrowing to ADDR_BITS.

Reset
REQ-029 Reset SHALL force state=IDLE, x=y=0, count=0, FIFO pointers=0, fb_we=0, fb_addr=0, fb_data=0, frame_done=0, overflow=0, in_full=0.
REQ-030 Reset asserted mid-frame SHALL discard FIFO contents and the partial frame; no fb_we SHALL follow reset release until start.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, the pixel channel width (8), and the default WIDTH/HEIGHT constants.
REQ-032 The FIFO SHALL be a sub-module pixel_fifo (parameterised depth/width, count output); the FSM, counters and framebuffer port SHALL live in pixel_frame_writer.

Verification
REQ-033 Reset, start, push 1024 pixels with fb_ready=1 -> 1024 fb_we, addresses 0..1023 in order, frame_done once with fb_addr=1023, state DONE.
REQ-034 Hold fb_ready=0 in RUN, push 5 pixels -> in_full=1 after 4th, 5th dropped, overflow=1 sticky.
REQ-035 Push 0x112233 at edge N in RUN with fb_ready=1 -> fb_we=1, fb_data=0x112233 in the cycle after edge N+1.
REQ-036 WIDTH=4, HEIGHT=2, full frame -> (x,y) wrap (3,0)->(0,1) at fb_addr 3->4; frame_done at fb_addr 7.
REQ-037 Full FIFO, simultaneous push and pop -> push rejected, count 4->3; non-full push plus pop -> count unchanged, order kept.
REQ-038 Assert reset after 100 pixels -> all outputs 0, IDLE; no fb_we until start; next frame starts at fb_addr 0.
